// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per clock, LSB first.
// Three-state FSM (IDLE/RUN/DONE) with registered busy/done/Diff/Bout.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic d;
    logic br_next;
    logic [WIDTH-1:0] res_next;

    assign d        = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign res_next = {d, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        br     <= Bin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    res_sr <= res_next;
                    // Diff is only touched here, so partial results never leak out
                    if (cnt == LAST) begin
                        Diff  <= res_next;
                        Bout  <= br_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Bout;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .Bin  (Bin),
        .busy (busy),
        .done (done),
        .Diff (Diff),
        .Bout (Bout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a, b,
                                         input logic bin);
        return {1'b0, a} - {1'b0, b} - {8'd0, bin};
    endfunction

    // pre=1: operands and start already driven before the accepting edge.
    // glitch: RUN cycle (1-based) in which a spurious start is pulsed, 0=none.
    task automatic op(input logic [7:0] a, b, input logic bin,
                      input bit pre, input int glitch, input string tag);
        int cyc;
        int bc;
        logic [8:0] e;
        e = model(a, b, bin);
        if (!pre) begin
            @(negedge clk);
            start = 1'b1;
            A = a;
            B = b;
            Bin = bin;
        end
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        bc = busy ? 1 : 0;
        chk({tag, "_busy1"}, 32'(busy), 32'd1);
        while (!done && cyc < 40) begin
            A = 8'($urandom);
            B = 8'($urandom);
            Bin = 1'($urandom);
            start = (cyc == glitch);
            @(negedge clk);
            cyc++;
            if (busy) bc++;
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(W + 1));
        chk({tag, "_busycnt"}, 32'(bc), 32'(W));
        chk({tag, "_res"}, {23'd0, Bout, Diff}, {23'd0, e});
        @(negedge clk);
        chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
        chk({tag, "_hold"}, {23'd0, Bout, Diff}, {23'd0, e});
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        int         t0;
        int         t1;
        int         seen;
        logic [7:0] qa[3];
        logic [7:0] qb[3];

        // reset overrides start
        start = 1'b1;
        A = 8'h5A;
        B = 8'h3C;
        Bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out", {21'd0, busy, done, Bout, Diff}, 32'd0);
        rst = 1'b0;

        // first edge with rst=0 and start=1 is accepted
        op(8'h5A, 8'h3C, 1'b0, 1'b1, 0, "r28");
        chk("r28_diff", 32'(Diff), 32'h1E);

        op(8'h00, 8'h01, 1'b0, 1'b0, 0, "r29a");
        chk("r29a_val", {23'd0, Bout, Diff}, 32'h1FF);
        op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, "r29b");
        chk("r29b_val", {23'd0, Bout, Diff}, 32'h1FF);

        // spurious start in RUN cycle 3 with A=B=1
        @(negedge clk);
        start = 1'b1;
        A = 8'h5A;
        B = 8'h3C;
        Bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        A = 8'h01;
        B = 8'h01;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("r30_done", 32'(done), 32'd1);
        chk("r30_res", {23'd0, Bout, Diff}, 32'h01E);
        @(negedge clk);
        repeat (W + 3) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("r30_nolaunch", 32'(seen), 32'd0);

        // reset in RUN cycle 4 aborts
        op(8'h10, 8'h20, 1'b0, 1'b0, 0, "pre31");
        @(negedge clk);
        start = 1'b1;
        A = 8'h77;
        B = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("r31_out", {21'd0, busy, done, Bout, Diff}, 32'd0);
        seen = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("r31_nodone", 32'(seen), 32'd0);
        chk("r31_zero", {23'd0, Bout, Diff}, 32'd0);
        op(8'h77, 8'h11, 1'b0, 1'b0, 0, "r31_fresh");

        // continuous start: three back-to-back operations
        qa[0] = 8'h5A; qb[0] = 8'h3C;
        qa[1] = 8'h03; qb[1] = 8'h80;
        qa[2] = 8'hC4; qb[2] = 8'h4C;
        @(negedge clk);
        start = 1'b1;
        Bin = 1'b0;
        A = qa[0];
        B = qb[0];
        t0 = 0;
        for (int k = 0; k < 3; k++) begin
            seen = 0;
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge clk);
                seen = 1;
            end
            chk("r32_done", 32'(done), 32'd1);
            chk("r32_res", {23'd0, Bout, Diff},
                {23'd0, model(qa[k], qb[k], 1'b0)});
            t1 = cycle;
            if (k > 0) chk("r32_space", 32'(t1 - t0), 32'(W + 2));
            t0 = t1;
            if (k < 2) begin
                A = qa[k+1];
                B = qb[k+1];
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end

        // exhaustive bit 0, upper bits zero
        for (int i = 0; i < 8; i++) begin
            ra = {7'd0, 1'(i >> 2)};
            rb = {7'd0, 1'(i >> 1)};
            rbin = 1'(i);
            op(ra, rb, rbin, 1'b0, 0, "bit0");
        end

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rbin = 1'($urandom);
            op(ra, rb, rbin, 1'b0, 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge only.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 start  input  1  SHALL request a new subtraction; it is sampled only in IDLE.
REQ-005 A  input  WIDTH  SHALL be the minuend, captured when start is accepted.
REQ-006 B  input  WIDTH  SHALL be the subtrahend, captured when start is accepted.
REQ-007 Bin  input  1  SHALL be the borrow-in, captured when start is accepted.
REQ-008 busy  output  1  SHALL be high exactly while the FSM is in RUN.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking Diff/Bout valid for a new result.
REQ-010 Diff  output  WIDTH  SHALL be the registered difference A - B - Bin modulo 2^WIDTH.
REQ-011 Bout  output  1  SHALL be the registered final borrow-out, 1 when A < B + Bin (unsigned).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 SHALL latch A, B, Bin into internal shift registers, clear the bit counter to 0, and go to RUN on the same edge.
REQ-014 IDLE with start=0 SHALL remain in IDLE with all outputs held.
REQ-015 Each RUN cycle SHALL process one bit, LSB first, using a full subtractor: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
REQ-016 The borrow register SHALL be initialised from the captured Bin and updated every RUN cycle.
REQ-017 The bit counter SHALL count 0..WIDTH-1; after processing bit WIDTH-1 the FSM SHALL go to DONE.
REQ-018 On the RUN-to-DONE edge, Diff SHALL load the assembled WIDTH-bit result and Bout SHALL load the final borrow.
REQ-019 done SHALL be high for exactly the single DONE cycle; DONE SHALL go to IDLE unconditionally on the next edge.
REQ-020 Latency: if start is sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH, and busy SHALL be high for exactly WIDTH cycles.
REQ-021 Diff and Bout SHALL hold their last values from the end of DONE until the next RUN-to-DONE edge; intermediate bits SHALL never appear on Diff.
REQ-022 start SHALL be ignored in RUN and DONE; A, B and Bin changes SHALL be ignored outside the accepting IDLE edge.
REQ-023 A start held high continuously SHALL launch back-to-back operations, with one IDLE cycle between a done pulse and the next busy.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH; underflow SHALL be reported only through Bout.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, counter=0, busy=0, done=0, Diff=0, Bout=0, and clear all internal registers, overriding start.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation: no done pulse, and Diff/Bout SHALL read 0 afterwards.
REQ-027 The first start SHALL be accepted on the first edge with rst=0 and start=1.

Verification (WIDTH=8)
REQ-028 A=0x5A, B=0x3C, Bin=0, start pulsed -> busy high for 8 cycles, then done pulse with Diff=0x1E, Bout=0.
REQ-029 A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Bout=1; then A=0xFF, B=0xFF, Bin=1 -> Diff=0xFF, Bout=1.
REQ-030 Start the operation in REQ-028, then pulse start with A=0x01, B=0x01 in RUN cycle 3 -> the second start is ignored and the result is still 0x1E/0.
REQ-031 Assert rst in RUN cycle 4 -> no done pulse, busy=0, Diff=0x00, Bout=0 on the next cycle; a fresh start completes normally.
REQ-032 Hold start=1 for three operations -> three done pulses spaced WIDTH+2 cycles apart, each with a correct result.
REQ-033 Run all 8 combinations of bit 0 with upper bits 0, plus 1000 random A/B/Bin sets -> each {Bout,Diff} equals a scoreboard A - B - Bin (mod 2^WIDTH).
